// File: rtl/payload_deserializer.sv
// Payload deserializer: assembles MSB-first serial payload bits into words and buffers them
// in a small FIFO with valid/ready output, plus sticky short/long/overflow error flags.
module payload_deserializer #(
  parameter int PAYLOAD_BITS = 10,
  parameter int DEPTH        = 4,
  parameter int CNT_W        = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ser_in,
  input  logic                    ser_valid,
  input  logic                    bit_en,
  output logic [PAYLOAD_BITS-1:0] out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CNT_W-1:0]        frame_cnt,
  output logic                    err_short,
  output logic                    err_long,
  output logic                    overflow,
  input  logic                    clr_err
);

  localparam int BC_W = $clog2(PAYLOAD_BITS + 1);
  localparam int PW   = $clog2(DEPTH);
  localparam int OC_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_HOLD} state_t;

  state_t                  state_q, state_d;
  logic [BC_W-1:0]         cnt_q, cnt_d;
  logic [PAYLOAD_BITS-2:0] shreg_q, shreg_d;
  logic [PAYLOAD_BITS-1:0] word;
  logic                    sample, push, set_short, set_long;

  logic [PAYLOAD_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]           wr_q, wr_d, rd_q, rd_d;
  logic [OC_W-1:0]         occ_q, occ_d;
  logic [CNT_W-1:0]        fcnt_q, fcnt_d;
  logic                    short_q, short_d, long_q, long_d, ovf_q, ovf_d;
  logic                    pop, full, push_ok, drop;

  assign sample = ser_valid & bit_en;
  assign word   = {shreg_q, ser_in};

  // Frame collection FSM
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    push      = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (!ser_valid) begin
          state_d   = S_IDLE;
          set_short = (cnt_q != '0);
          cnt_d     = '0;
        end else begin
          state_d = S_COLLECT;
          if (sample) begin
            shreg_d = word[PAYLOAD_BITS-2:0];
            if (cnt_q == BC_W'(PAYLOAD_BITS - 1)) begin
              push    = 1'b1;
              cnt_d   = '0;
              state_d = S_HOLD;
            end else begin
              cnt_d = cnt_q + BC_W'(1);
            end
          end
        end
      end
      S_HOLD: begin
        if (!ser_valid) state_d = S_IDLE;
        else if (sample) set_long = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // FIFO control; a simultaneous pop frees the slot a full-FIFO push needs
  assign pop     = out_valid & out_ready;
  assign full    = (occ_q == OC_W'(DEPTH));
  assign push_ok = push & (~full | pop);
  assign drop    = push & full & ~pop;

  always_comb begin
    wr_d    = wr_q + PW'(push_ok);
    rd_d    = rd_q + PW'(pop);
    occ_d   = occ_q + OC_W'(push_ok) - OC_W'(pop);
    fcnt_d  = fcnt_q + CNT_W'(push_ok);
    short_d = (short_q & ~clr_err) | set_short;
    long_d  = (long_q & ~clr_err) | set_long;
    ovf_d   = (ovf_q & ~clr_err) | drop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      wr_q    <= '0;
      rd_q    <= '0;
      occ_q   <= '0;
      fcnt_q  <= '0;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      occ_q   <= occ_d;
      fcnt_q  <= fcnt_d;
      short_q <= short_d;
      long_q  <= long_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage is data-only; empty-FIFO output is forced to zero instead of resetting it
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_q] <= word;
  end

  assign out_valid = (occ_q != '0);
  assign out_data  = out_valid ? mem[rd_q] : '0;
  assign frame_cnt = fcnt_q;
  assign err_short = short_q;
  assign err_long  = long_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_payload_deserializer.sv
// Scoreboard bench for payload_deserializer: directed frames push expected words,
// a negedge monitor compares every word the DUT hands off.
module tb_payload_deserializer;

  logic       clk = 1'b0;
  logic       rst, ser_in, ser_valid, bit_en, out_ready, clr_err;
  logic [9:0] out_data;
  logic       out_valid, err_short, err_long, overflow;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;
  logic [9:0] exp_q [$];

  payload_deserializer #(.PAYLOAD_BITS(10), .DEPTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .bit_en(bit_en),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .frame_cnt(frame_cnt), .err_short(err_short), .err_long(err_long),
    .overflow(overflow), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every handshake must deliver the oldest outstanding expected word
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", out_data);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", out_data, e);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic frame(input logic [9:0] w, input int nbits, input int extra,
                       input bit exp_push, input bit rdy_last, input bit clr_end);
    ser_valid = 1'b1;
    tick();
    for (int i = 0; i < nbits + extra; i++) begin
      ser_in = (i < nbits) ? w[9-i] : 1'b1;
      if (rdy_last && i == nbits - 1) out_ready = 1'b1;
      if (exp_push && i == nbits - 1) begin
        exp_q.push_back(w);
        exp_cnt++;
      end
      bit_en = 1'b1;
      tick();
      bit_en = 1'b0;
      tick();
    end
    if (clr_end) clr_err = 1'b1;
    ser_valid = 1'b0;
    tick();
    clr_err = 1'b0;
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; ser_in = 1'b0; ser_valid = 1'b0; bit_en = 1'b0;
    out_ready = 1'b0; clr_err = 1'b0;
    repeat (2) tick();
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_cnt", frame_cnt, 0);
    chk("rst_flags", {err_short, err_long, overflow}, 0);
    rst = 1'b0;
    tick();

    // 1: basic frame, word held while not ready
    frame(10'b1011001011, 10, 0, 1, 0, 0);
    chk("t1_valid", out_valid, 1);
    chk("t1_data", out_data, 10'b1011001011);
    chk("t1_cnt", frame_cnt, 1);
    chk("t1_flags", {err_short, err_long, overflow}, 0);
    tick();
    chk("t1_hold", out_data, 10'b1011001011);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t1_drained", out_valid, 0);

    // 2: short frame, clear, then set-beats-clear
    frame(10'h3FF, 6, 0, 0, 0, 0);
    chk("t2_short", err_short, 1);
    chk("t2_valid", out_valid, 0);
    chk("t2_cnt", frame_cnt, exp_cnt);
    clear_flags();
    chk("t2_clr", err_short, 0);
    frame(10'h155, 3, 0, 0, 0, 1);
    chk("t2_set_wins", err_short, 1);
    clear_flags();

    // 3: long frame
    frame(10'h2A5, 10, 2, 1, 0, 0);
    chk("t3_long", err_long, 1);
    chk("t3_short", err_short, 0);
    chk("t3_cnt", frame_cnt, exp_cnt);
    chk("t3_empty", out_valid, 0);
    clear_flags();
    chk("t3_clr", err_long, 0);

    // 4: overflow with consumer stalled
    out_ready = 1'b0;
    for (int k = 1; k <= 5; k++) frame(10'(k), 10, 0, (k <= 4), 0, 0);
    chk("t4_ovf", overflow, 1);
    chk("t4_cnt", frame_cnt, exp_cnt);
    chk("t4_head", out_data, 10'h001);
    out_ready = 1'b1;
    repeat (6) tick();
    chk("t4_valid", out_valid, 0);
    chk("t4_data0", out_data, 0);
    chk("t4_q", exp_q.size(), 0);
    out_ready = 1'b0;
    clear_flags();
    chk("t4_clr", overflow, 0);

    // 5: full FIFO push accepted by same-cycle pop
    for (int k = 1; k <= 4; k++) frame(10'(k), 10, 0, 1, 0, 0);
    frame(10'h005, 10, 0, 1, 1, 0);
    chk("t5_ovf", overflow, 0);
    chk("t5_cnt", frame_cnt, exp_cnt);
    repeat (6) tick();
    chk("t5_valid", out_valid, 0);
    chk("t5_q", exp_q.size(), 0);

    // 6: asynchronous reset mid-frame
    out_ready = 1'b0;
    ser_valid = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      ser_in = 1'b1; bit_en = 1'b1; tick();
      bit_en = 1'b0; tick();
    end
    rst = 1'b1;
    #2;
    chk("t6_valid", out_valid, 0);
    chk("t6_cnt", frame_cnt, 0);
    chk("t6_flags", {err_short, err_long, overflow}, 0);
    ser_valid = 1'b0;
    tick();
    rst = 1'b0;
    exp_cnt = 0;
    tick();
    frame(10'h3C3, 10, 0, 1, 0, 0);
    chk("t6_data", out_data, 10'h3C3);
    chk("t6_fcnt", frame_cnt, 1);
    chk("t6_flags2", {err_short, err_long, overflow}, 0);
    out_ready = 1'b1;
    repeat (3) tick();
    chk("t6_q", exp_q.size(), 0);
    chk("t6_empty", out_valid, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
